// File: rtl/libAritimeticalControl.sv
// ALU control codes driven on aluOp.
package libAritimeticalControl;

  localparam logic [3:0] ARCTRL_ZERO = 4'd0;
  localparam logic [3:0] ARCTRL_ADD  = 4'd1;
  localparam logic [3:0] ARCTRL_SUB  = 4'd2;
  localparam logic [3:0] ARCTRL_AND  = 4'd3;
  localparam logic [3:0] ARCTRL_OR   = 4'd4;
  localparam logic [3:0] ARCTRL_XOR  = 4'd5;
  localparam logic [3:0] ARCTRL_SLT  = 4'd6;
  localparam logic [3:0] ARCTRL_LU   = 4'd7;
  // ALU decodes the funct field itself for R-type.
  localparam logic [3:0] ARCTRL_FUNC = 4'd15;

endpackage

// File: rtl/libInstructions.sv
// MIPS primary opcode values (instruction[31:26]) used by the control path.
package libInstructions;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/libMulticycleControl.sv
// State encoding, opcode classes and operand-select constants for the
// multicycle controller.
package libMulticycleControl;

  typedef enum logic [3:0] {
    MC_FETCH     = 4'd0,
    MC_DECODE    = 4'd1,
    MC_MEM_ADDR  = 4'd2,
    MC_MEM_READ  = 4'd3,
    MC_MEM_WB    = 4'd4,
    MC_MEM_WRITE = 4'd5,
    MC_EXEC_R    = 4'd6,
    MC_WB_R      = 4'd7,
    MC_EXEC_I    = 4'd8,
    MC_WB_I      = 4'd9,
    MC_BRANCH    = 4'd10,
    MC_JUMP      = 4'd11
  } mc_state_t;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_R,
    CLS_I,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } mc_class_t;

  localparam logic       ALUA_PC      = 1'b0;
  localparam logic       ALUA_REG     = 1'b1;
  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_SEXT    = 2'b10;
  localparam logic [1:0] ALUB_SHIFT   = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_op_decode.sv
// Combinational opcode classifier: next-state class, I-type ALU code, illegal flag.
module multicycle_op_decode
  import libInstructions::*, libAritimeticalControl::*, libMulticycleControl::*;
(
  input  logic [5:0] opcode_i,
  output mc_class_t  class_o,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  // Map each supported opcode to its sequence class; anything else is illegal.
  always_comb begin
    class_o   = CLS_ILLEGAL;
    alu_op_o  = ARCTRL_ZERO;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_LW, OP_SW:    class_o = CLS_MEM;
      OP_RTYPE:        class_o = CLS_R;
      OP_ADDI: begin   class_o = CLS_I; alu_op_o = ARCTRL_ADD; end
      OP_ANDI: begin   class_o = CLS_I; alu_op_o = ARCTRL_AND; end
      OP_ORI:  begin   class_o = CLS_I; alu_op_o = ARCTRL_OR;  end
      OP_XORI: begin   class_o = CLS_I; alu_op_o = ARCTRL_XOR; end
      OP_SLTI: begin   class_o = CLS_I; alu_op_o = ARCTRL_SLT; end
      OP_LUI:  begin   class_o = CLS_I; alu_op_o = ARCTRL_LU;  end
      OP_BEQ, OP_BNE:  class_o = CLS_BRANCH;
      OP_J:            class_o = CLS_JUMP;
      default:         illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing FSM: drives datapath enables/selects per state,
// stalling in memory states on memReady.
module multicycle_controller
  import libInstructions::*, libAritimeticalControl::*, libMulticycleControl::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [31:26] instruction,
  input  logic         zero,
  input  logic         memReady,
  output logic         pcWrite,
  output logic         iorD,
  output logic         irWrite,
  output logic         memRead,
  output logic         memWrite,
  output logic         memToReg,
  output logic         regDst,
  output logic         regWrite,
  output logic         aluSrcA,
  output logic [1:0]   aluSrcB,
  output logic [3:0]   aluOp,
  output logic [1:0]   pcSource,
  output logic         instrDone,
  output logic         illegal
);

  mc_state_t  state_q, state_d;
  mc_class_t  op_class;
  logic [3:0] imm_alu_op;
  logic       op_illegal;

  multicycle_op_decode u_op_decode (
    .opcode_i  (instruction),
    .class_o   (op_class),
    .alu_op_o  (imm_alu_op),
    .illegal_o (op_illegal)
  );

  // State register; reset returns to FETCH asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= MC_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode; outputs are forced low for the whole of reset
  // so an in-flight write or writeback is dropped without waiting for an edge.
  always_comb begin
    state_d   = state_q;
    pcWrite   = 1'b0;
    iorD      = 1'b0;
    irWrite   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    regDst    = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = ALUA_PC;
    aluSrcB   = ALUB_REG;
    aluOp     = ARCTRL_ZERO;
    pcSource  = PCSRC_ALU;
    instrDone = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      case (state_q)
        MC_FETCH: begin
          memRead = 1'b1;
          aluSrcB = ALUB_FOUR;
          aluOp   = ARCTRL_ADD;
          irWrite = memReady;
          pcWrite = memReady;
          if (memReady) state_d = MC_DECODE;
        end
        MC_DECODE: begin
          aluSrcB = ALUB_SHIFT;
          aluOp   = ARCTRL_ADD;
          case (op_class)
            CLS_MEM:    state_d = MC_MEM_ADDR;
            CLS_R:      state_d = MC_EXEC_R;
            CLS_I:      state_d = MC_EXEC_I;
            CLS_BRANCH: state_d = MC_BRANCH;
            CLS_JUMP:   state_d = MC_JUMP;
            default: begin
              state_d   = MC_FETCH;
              illegal   = op_illegal;
              instrDone = 1'b1;
            end
          endcase
        end
        MC_MEM_ADDR: begin
          aluSrcA = ALUA_REG;
          aluSrcB = ALUB_SEXT;
          aluOp   = ARCTRL_ADD;
          state_d = (instruction == OP_LW) ? MC_MEM_READ : MC_MEM_WRITE;
        end
        MC_MEM_READ: begin
          memRead = 1'b1;
          iorD    = 1'b1;
          if (memReady) state_d = MC_MEM_WB;
        end
        MC_MEM_WB: begin
          regWrite  = 1'b1;
          memToReg  = 1'b1;
          instrDone = 1'b1;
          state_d   = MC_FETCH;
        end
        MC_MEM_WRITE: begin
          memWrite  = 1'b1;
          iorD      = 1'b1;
          instrDone = memReady;
          if (memReady) state_d = MC_FETCH;
        end
        MC_EXEC_R: begin
          aluSrcA = ALUA_REG;
          aluSrcB = ALUB_REG;
          aluOp   = ARCTRL_FUNC;
          state_d = MC_WB_R;
        end
        MC_WB_R: begin
          regWrite  = 1'b1;
          regDst    = 1'b1;
          instrDone = 1'b1;
          state_d   = MC_FETCH;
        end
        MC_EXEC_I: begin
          aluSrcA = ALUA_REG;
          aluSrcB = ALUB_SEXT;
          aluOp   = imm_alu_op;
          state_d = MC_WB_I;
        end
        MC_WB_I: begin
          regWrite  = 1'b1;
          instrDone = 1'b1;
          state_d   = MC_FETCH;
        end
        MC_BRANCH: begin
          aluSrcA   = ALUA_REG;
          aluSrcB   = ALUB_REG;
          aluOp     = ARCTRL_SUB;
          pcSource  = PCSRC_ALUOUT;
          pcWrite   = (instruction == OP_BNE) ? ~zero : zero;
          instrDone = 1'b1;
          state_d   = MC_FETCH;
        end
        MC_JUMP: begin
          pcSource  = PCSRC_JUMP;
          pcWrite   = 1'b1;
          instrDone = 1'b1;
          state_d   = MC_FETCH;
        end
        default: state_d = MC_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors against
// hand-derived expectations.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  instruction;
  logic        zero;
  logic        memReady;
  logic        pcWrite, iorD, irWrite, memRead, memWrite, memToReg, regDst, regWrite;
  logic        aluSrcA, instrDone, illegal;
  logic [1:0]  aluSrcB, pcSource;
  logic [3:0]  aluOp;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .zero        (zero),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .iorD        (iorD),
    .irWrite     (irWrite),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memToReg    (memToReg),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSource    (pcSource),
    .instrDone   (instrDone),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  // {pcWrite,iorD,irWrite,memRead,memWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,pcSource,instrDone,illegal}
  logic [18:0] outs;
  assign outs = {pcWrite, iorD, irWrite, memRead, memWrite, memToReg, regDst, regWrite,
                 aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegal};

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

  localparam logic [3:0] A_ZERO = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4;
  localparam logic [3:0] A_XOR = 4'd5, A_SLT = 4'd6, A_LU = 4'd7, A_FUNC = 4'd15;

  localparam logic [18:0] E_ZERO    = 19'd0;
  localparam logic [18:0] E_FETCH_R = {1'b1, 1'b0, 1'b1, 1'b1, 5'b0, 2'b01, A_ADD, 2'b00, 2'b00};
  localparam logic [18:0] E_FETCH_W = {1'b0, 1'b0, 1'b0, 1'b1, 5'b0, 2'b01, A_ADD, 2'b00, 2'b00};
  localparam logic [18:0] E_DECODE  = {9'b0, 2'b11, A_ADD, 2'b00, 2'b00};
  localparam logic [18:0] E_DEC_ILL = {9'b0, 2'b11, A_ADD, 2'b00, 2'b11};
  localparam logic [18:0] E_MEMADDR = {8'b0, 1'b1, 2'b10, A_ADD, 4'b0};
  localparam logic [18:0] E_MEMREAD = {1'b0, 1'b1, 1'b0, 1'b1, 5'b0, 2'b00, A_ZERO, 4'b0};
  localparam logic [18:0] E_MEMWB   = {5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, A_ZERO, 2'b00, 2'b10};
  localparam logic [18:0] E_MEMWR_W = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0, 2'b00, A_ZERO, 4'b0};
  localparam logic [18:0] E_MEMWR_R = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0, 2'b00, A_ZERO, 2'b00, 2'b10};
  localparam logic [18:0] E_EXECR   = {8'b0, 1'b1, 2'b00, A_FUNC, 4'b0};
  localparam logic [18:0] E_WBR     = {6'b0, 1'b1, 1'b1, 1'b0, 2'b00, A_ZERO, 2'b00, 2'b10};
  localparam logic [18:0] E_WBI     = {7'b0, 1'b1, 1'b0, 2'b00, A_ZERO, 2'b00, 2'b10};
  localparam logic [18:0] E_BR_T    = {1'b1, 7'b0, 1'b1, 2'b00, A_SUB, 2'b01, 2'b10};
  localparam logic [18:0] E_BR_N    = {1'b0, 7'b0, 1'b1, 2'b00, A_SUB, 2'b01, 2'b10};
  localparam logic [18:0] E_JUMP    = {1'b1, 8'b0, 2'b00, A_ZERO, 2'b10, 2'b10};

  // Tasks are entered/left at posedge+1 with state FETCH (except reset entry).

  task automatic test_reset();
    logic [18:0] ex [5];
    reset = 1'b1; memReady = 1'b1; zero = 1'b1; instruction = OP_J;
    #1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (outs !== E_ZERO) begin
        n_err++;
        $display("FAIL reset_outs cycle %0d: got %b expected %b", i, outs, E_ZERO);
      end
      @(posedge clock); #1;
    end
    reset = 1'b0; instruction = OP_R; zero = 1'b0;
    ex[0] = E_FETCH_R; ex[1] = E_DECODE; ex[2] = E_EXECR; ex[3] = E_WBR; ex[4] = E_FETCH_R;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_err++;
        $display("FAIL rtype_seq cycle %0d: got %b expected %b", i, outs, ex[i]);
      end
      if (i < 4) begin @(posedge clock); #1; end
    end
  endtask

  task automatic test_lw_stall();
    logic [18:0] ex [11];
    logic        rdy [11];
    int          irw_cnt = 0;
    instruction = OP_LW;
    ex[0] = E_FETCH_W;  rdy[0] = 1'b0;
    ex[1] = E_FETCH_W;  rdy[1] = 1'b0;
    ex[2] = E_FETCH_R;  rdy[2] = 1'b1;
    ex[3] = E_DECODE;   rdy[3] = 1'b1;
    ex[4] = E_MEMADDR;  rdy[4] = 1'b1;
    ex[5] = E_MEMREAD;  rdy[5] = 1'b0;
    ex[6] = E_MEMREAD;  rdy[6] = 1'b0;
    ex[7] = E_MEMREAD;  rdy[7] = 1'b0;
    ex[8] = E_MEMREAD;  rdy[8] = 1'b1;
    ex[9] = E_MEMWB;    rdy[9] = 1'b1;
    ex[10] = E_FETCH_R; rdy[10] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      memReady = rdy[i];
      #2;
      if (i < 10 && irWrite === 1'b1) irw_cnt++;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_err++;
        $display("FAIL lw_stall cycle %0d: got %b expected %b", i, outs, ex[i]);
      end
      if (i < 10) begin @(posedge clock); #1; end
    end
    n_cmp++;
    if (irw_cnt !== 1) begin
      n_err++;
      $display("FAIL lw_irwrite_pulses: got %0d expected 1", irw_cnt);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op  [4];
    logic        z   [4];
    logic [18:0] br  [4];
    logic [18:0] ex  [4];
    op[0] = OP_BEQ; z[0] = 1'b1; br[0] = E_BR_T;
    op[1] = OP_BNE; z[1] = 1'b1; br[1] = E_BR_N;
    op[2] = OP_BNE; z[2] = 1'b0; br[2] = E_BR_T;
    op[3] = OP_BEQ; z[3] = 1'b0; br[3] = E_BR_N;
    memReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instruction = op[k]; zero = z[k];
      ex[0] = E_FETCH_R; ex[1] = E_DECODE; ex[2] = br[k]; ex[3] = E_FETCH_R;
      for (int i = 0; i < 4; i++) begin
        #2;
        n_cmp++;
        if (outs !== ex[i]) begin
          n_err++;
          $display("FAIL branch%0d cycle %0d: got %b expected %b", k, i, outs, ex[i]);
        end
        if (i < 3) begin @(posedge clock); #1; end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_itype();
    logic [5:0]  op [6];
    logic [3:0]  ac [6];
    logic [18:0] ex [5];
    op[0] = OP_ADDI; ac[0] = A_ADD;
    op[1] = OP_ANDI; ac[1] = A_AND;
    op[2] = OP_ORI;  ac[2] = A_OR;
    op[3] = OP_XORI; ac[3] = A_XOR;
    op[4] = OP_SLTI; ac[4] = A_SLT;
    op[5] = OP_LUI;  ac[5] = A_LU;
    memReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instruction = op[k];
      ex[0] = E_FETCH_R; ex[1] = E_DECODE; ex[2] = {8'b0, 1'b1, 2'b10, ac[k], 4'b0};
      ex[3] = E_WBI; ex[4] = E_FETCH_R;
      for (int i = 0; i < 5; i++) begin
        #2;
        n_cmp++;
        if (outs !== ex[i]) begin
          n_err++;
          $display("FAIL itype op=%b cycle %0d: got %b expected %b", op[k], i, outs, ex[i]);
        end
        if (i < 4) begin @(posedge clock); #1; end
      end
    end
  endtask

  task automatic test_jump_sw();
    logic [18:0] ex [7];
    logic        rdy [7];
    memReady = 1'b1; instruction = OP_J;
    ex[0] = E_FETCH_R; ex[1] = E_DECODE; ex[2] = E_JUMP; ex[3] = E_FETCH_R;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_err++;
        $display("FAIL jump cycle %0d: got %b expected %b", i, outs, ex[i]);
      end
      if (i < 3) begin @(posedge clock); #1; end
    end
    instruction = OP_SW;
    ex[0] = E_FETCH_R; rdy[0] = 1'b1;
    ex[1] = E_DECODE;  rdy[1] = 1'b1;
    ex[2] = E_MEMADDR; rdy[2] = 1'b1;
    ex[3] = E_MEMWR_W; rdy[3] = 1'b0;
    ex[4] = E_MEMWR_W; rdy[4] = 1'b0;
    ex[5] = E_MEMWR_R; rdy[5] = 1'b1;
    ex[6] = E_FETCH_R; rdy[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      memReady = rdy[i];
      #2;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_err++;
        $display("FAIL sw_stall cycle %0d: got %b expected %b", i, outs, ex[i]);
      end
      if (i < 6) begin @(posedge clock); #1; end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] ex [3];
    memReady = 1'b1; instruction = OP_BAD;
    ex[0] = E_FETCH_R; ex[1] = E_DEC_ILL; ex[2] = E_FETCH_R;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_err++;
        $display("FAIL illegal cycle %0d: got %b expected %b", i, outs, ex[i]);
      end
      if (i < 2) begin @(posedge clock); #1; end
    end
  endtask

  task automatic test_reset_abort();
    logic [18:0] ex [4];
    memReady = 1'b1; instruction = OP_SW;
    ex[0] = E_FETCH_R; ex[1] = E_DECODE; ex[2] = E_MEMADDR; ex[3] = E_MEMWR_W;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memReady = 1'b0;
      #2;
      n_cmp++;
      if (outs !== ex[i]) begin
        n_err++;
        $display("FAIL abort_pre cycle %0d: got %b expected %b", i, outs, ex[i]);
      end
      if (i < 3) begin @(posedge clock); #1; end
    end
    // Mid-cycle reset: memWrite must drop with no clock edge.
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== E_ZERO) begin
      n_err++;
      $display("FAIL abort_async: got %b expected %b", outs, E_ZERO);
    end
    @(posedge clock); #1;
    memReady = 1'b1;
    reset = 1'b0;
    #2;
    n_cmp++;
    if (outs !== E_FETCH_R) begin
      n_err++;
      $display("FAIL abort_fetch: got %b expected %b", outs, E_FETCH_R);
    end
    @(posedge clock); #1;
    #2;
    n_cmp++;
    if (outs !== E_DECODE) begin
      n_err++;
      $display("FAIL abort_decode: got %b expected %b", outs, E_DECODE);
    end
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_branch();
    test_itype();
    test_jump_sw();
    test_illegal();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
